// File: rtl/rdoq_scan_pkg.sv
// Shared types for the RDOQ coefficient-group scan sequencer.
// Holds the CG grid size limit, index/position types and the block size helper.
package rdoq_scan_pkg;

  localparam int MAX_CG = 64;

  typedef logic [1:0] log2_grp_t;
  typedef logic [5:0] cg_idx_t;
  typedef logic [6:0] cg_pos_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cgseq_state_e;

  // Number of CGs in a block, saturated to the largest supported grid.
  function automatic logic [6:0] num_cg_f(input log2_grp_t lw, input log2_grp_t lh);
    logic [2:0] sum;
    sum = {1'b0, lw} + {1'b0, lh};
    if (sum >= 3'd6) return 7'(MAX_CG);
    return 7'd1 << sum;
  endfunction

endpackage

// File: rtl/cg_scan_sequencer.sv
// Walks the CG scan order of one transform block, addressing the shared CG ROM
// and streaming one captured CG position per cycle over a valid/ready interface.
module cg_scan_sequencer
  import rdoq_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       reverse,
  input  logic [1:0] log2_w_grp,
  input  logic [1:0] log2_h_grp,
  input  logic [5:0] last_idx,
  output logic [1:0] rom_lw,
  output logic [1:0] rom_lh,
  output logic [5:0] rom_addr,
  input  logic [6:0] rom_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_cg_pos,
  output logic [5:0] out_scan_idx,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       clamp_err
);

  cgseq_state_e state, next_state;

  cg_idx_t idx;
  cg_idx_t eff_last;
  logic    rev;

  logic       start_ok;
  logic       load;
  logic       handshake;
  logic       at_end;
  cg_idx_t    end_idx;
  logic [6:0] num_cg_in;
  logic [6:0] num_cg_m1;
  logic       clamp_in;
  cg_idx_t    eff_in;

  assign rom_addr = idx;
  assign busy     = (state != IDLE);

  always_comb begin
    num_cg_in = num_cg_f(log2_w_grp, log2_h_grp);
    num_cg_m1 = num_cg_in - 7'd1;
    clamp_in  = ({1'b0, last_idx} >= num_cg_in);
    eff_in    = clamp_in ? num_cg_m1[5:0] : last_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Abort overrides everything, including a pending start or handshake.
  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    load       = 1'b0;
    handshake  = out_valid && out_ready;
    end_idx    = rev ? 6'd0 : eff_last;
    at_end     = (idx == end_idx);
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            start_ok   = 1'b1;
            next_state = RUN;
          end
        end
        RUN: begin
          load = !out_valid || out_ready;
          if (load && at_end) next_state = DRAIN;
        end
        DRAIN: begin
          if (handshake) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      eff_last     <= '0;
      rev          <= 1'b0;
      rom_lw       <= '0;
      rom_lh       <= '0;
      out_valid    <= 1'b0;
      out_cg_pos   <= '0;
      out_scan_idx <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
      clamp_err    <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      clamp_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        rom_lw    <= log2_w_grp;
        rom_lh    <= log2_h_grp;
        rev       <= reverse;
        eff_last  <= eff_in;
        idx       <= reverse ? eff_in : 6'd0;
        clamp_err <= clamp_in;
      end
      // Stepping stops at the end index, so idx never wraps.
      if (load) begin
        out_cg_pos   <= rom_data;
        out_scan_idx <= idx;
        out_valid    <= 1'b1;
        out_last     <= at_end;
        if (!at_end) idx <= rev ? idx - 6'd1 : idx + 6'd1;
      end
      if (state == DRAIN && handshake) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cg_scan_sequencer.sv
// Directed bench for cg_scan_sequencer with a behavioural CG ROM alongside the DUT.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cg_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       reverse;
  logic [1:0] log2_w_grp;
  logic [1:0] log2_h_grp;
  logic [5:0] last_idx;
  logic [1:0] rom_lw;
  logic [1:0] rom_lh;
  logic [5:0] rom_addr;
  logic [6:0] rom_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_cg_pos;
  logic [5:0] out_scan_idx;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       clamp_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] T44 [16] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd8, 7'd9,
                                      7'd6, 7'd7, 7'd12, 7'd13, 7'd10, 7'd11, 7'd14, 7'd15};
  localparam logic [6:0] T22 [4]  = '{7'd0, 7'd1, 7'd3, 7'd2};

  always #5 clk = ~clk;

  cg_scan_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .reverse      (reverse),
    .log2_w_grp   (log2_w_grp),
    .log2_h_grp   (log2_h_grp),
    .last_idx     (last_idx),
    .rom_lw       (rom_lw),
    .rom_lh       (rom_lh),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cg_pos   (out_cg_pos),
    .out_scan_idx (out_scan_idx),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .clamp_err    (clamp_err)
  );

  // Stand-in for rom_coefficient_groups: hand tables for 4x4 and 2x2, raster order otherwise.
  function automatic logic [6:0] rom_model(input logic [1:0] lw, input logic [1:0] lh,
                                           input logic [5:0] a);
    if (lw == 2'd2 && lh == 2'd2) return T44[a[3:0]];
    if (lw == 2'd1 && lh == 2'd1) return T22[a[1:0]];
    return {1'b0, a};
  endfunction

  assign rom_data = rom_model(rom_lw, rom_lh, rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_clamp"}, 32'(clamp_err), 32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_pos"},   32'(out_cg_pos), 32'd0);
    check({tag, "_sidx"},  32'(out_scan_idx), 32'd0);
    check({tag, "_rom"},   {26'd0, rom_lw, rom_lh, rom_addr[1:0]}, 32'd0);
    check({tag, "_addr"},  32'(rom_addr), 32'd0);
  endtask

  // Starts a scan on the current falling edge and follows it to done (or abort).
  task automatic run_scan(input logic [1:0] lw, input logic [1:0] lh, input logic rev,
                          input logic [5:0] last, input bit toggle, input int abort_at,
                          input bit poke);
    int num, eff, k, cyc, exp_idx;
    bit stalled, poked, aborted;
    logic [6:0] held_pos;
    logic [5:0] held_idx;
    logic       held_last;
    num = 1 << (int'(lw) + int'(lh));
    eff = (int'(last) >= num) ? num - 1 : int'(last);
    log2_w_grp = lw;
    log2_h_grp = lh;
    reverse    = rev;
    last_idx   = last;
    out_ready  = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  32'(busy),      32'd1);
    check("start_valid", 32'(out_valid), 32'd0);
    check("start_done",  32'(done),      32'd0);
    check("start_clamp", 32'(clamp_err), 32'(int'(last) >= num));
    check("start_rom",   {28'd0, rom_lw, rom_lh}, {28'd0, lw, lh});
    k = 0; cyc = 0; stalled = 0; poked = 0; aborted = 0;
    held_pos = '0; held_idx = '0; held_last = 1'b0;
    while (k <= eff && cyc < 400 && !aborted) begin
      start = 1'b0;
      log2_w_grp = lw;
      log2_h_grp = lh;
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == 1) check("latency_valid", 32'(out_valid), 32'd1);
      if (out_valid && stalled) begin
        check("stall_pos",  32'(out_cg_pos),   32'(held_pos));
        check("stall_sidx", 32'(out_scan_idx), 32'(held_idx));
        check("stall_last", 32'(out_last),     32'(held_last));
      end
      stalled = out_valid && !out_ready;
      held_pos = out_cg_pos; held_idx = out_scan_idx; held_last = out_last;
      if (poke && !poked && k == 5) begin
        start = 1'b1;
        log2_w_grp = 2'd0;
        log2_h_grp = 2'd0;
        poked = 1;
      end
      if (out_valid && k == abort_at) begin
        abort = 1'b1;
        aborted = 1;
      end else if (out_valid && out_ready) begin
        exp_idx = rev ? eff - k : k;
        check("cg_sidx", 32'(out_scan_idx), 32'(exp_idx));
        check("cg_pos",  32'(out_cg_pos),   32'(rom_model(lw, lh, 6'(exp_idx))));
        check("cg_last", 32'(out_last),     32'(k == eff));
        check("cg_busy", 32'(busy),         32'd1);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (aborted) begin
      abort = 1'b0;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy",  32'(busy),      32'd0);
      check("abort_done",  32'(done),      32'd0);
      check("abort_last",  32'(out_last),  32'd0);
      check("abort_clamp", 32'(clamp_err), 32'd0);
    end else begin
      check("scan_timeout", 32'(k), 32'(eff + 1));
      check("end_done",  32'(done),      32'd1);
      check("end_valid", 32'(out_valid), 32'd0);
      check("end_busy",  32'(busy),      32'd0);
      check("end_rom",   {28'd0, rom_lw, rom_lh}, {28'd0, lw, lh});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; reverse = 1'b0;
    log2_w_grp = '0; log2_h_grp = '0; last_idx = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    $display("[TB] 4x4 reverse full scan");
    run_scan(2'd2, 2'd2, 1'b1, 6'd15, 1'b0, -1, 1'b0);
    $display("[TB] 2x2 forward with toggled ready, started in the done cycle");
    run_scan(2'd1, 2'd1, 1'b0, 6'd3, 1'b1, -1, 1'b0);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    $display("[TB] 1x1 with clamped last index");
    run_scan(2'd0, 2'd0, 1'b0, 6'd5, 1'b0, -1, 1'b0);
    $display("[TB] 8x8 reverse aborted at tenth CG, then rerun");
    run_scan(2'd3, 2'd3, 1'b1, 6'd63, 1'b0, 9, 1'b0);
    @(negedge clk);
    check("abort_still_idle", 32'(busy), 32'd0);
    run_scan(2'd3, 2'd3, 1'b1, 6'd63, 1'b0, -1, 1'b0);
    $display("[TB] 2x8 forward with ignored start mid-scan");
    run_scan(2'd1, 2'd3, 1'b0, 6'd15, 1'b0, -1, 1'b1);
    $display("[TB] reset during RUN");
    log2_w_grp = 2'd2; log2_h_grp = 2'd2; reverse = 1'b0; last_idx = 6'd15;
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrun_reset");
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
